// File: rtl/capture_datapath_mc.sv
`default_nettype none
// ============================================================================
// Module   : capture_datapath_mc
// Purpose  : Multi-channel pre/post-trigger capture buffer with byte readout.
// Revision : 1.0
// ============================================================================
module capture_datapath_mc #(
  parameter int SAMPLE_WIDTH = 12,
  parameter int NUM_CH       = 2,
  parameter int DEPTH        = 1024,
  parameter int ADDR_WIDTH   = 10,
  parameter int PRETRIG      = 256
) (
  input  logic                           i_clk,
  input  logic                           i_RESET,
  input  logic                           i_arm,
  input  logic                           i_sample_valid,
  input  logic [NUM_CH*SAMPLE_WIDTH-1:0] i_sample_data,
  input  logic                           i_trigger,
  input  logic                           i_tx_ready,
  output logic [7:0]                     o_tx_data,
  output logic                           o_tx_valid,
  output logic                           o_armed,
  output logic                           o_busy,
  output logic                           o_TRANSFER_DONE
);

  localparam int DW   = NUM_CH * SAMPLE_WIDTH;
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [ADDR_WIDTH-1:0] c_pretrig = ADDR_WIDTH'(PRETRIG);
  localparam logic [ADDR_WIDTH-1:0] c_postcnt = ADDR_WIDTH'(DEPTH - PRETRIG - 1);
  localparam logic [ADDR_WIDTH-1:0] c_last    = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] c_one     = ADDR_WIDTH'(1);
  localparam logic [CH_W-1:0]       c_last_ch = CH_W'(NUM_CH - 1);
  localparam logic [7:0]            c_sync    = 8'hA5;
  localparam logic [7:0]            c_nch     = 8'(NUM_CH);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PREFILL   = 3'd1,
    S_WAIT_TRIG = 3'd2,
    S_POST      = 3'd3,
    S_READOUT   = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] trig_ptr_q, trig_ptr_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] smp_q, smp_d;
  logic [1:0]            hdr_q, hdr_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic                  lo_q, lo_d;
  logic                  fetch_q, fetch_d;
  logic                  last_q, last_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  done_q, done_d;
  logic                  armed_q, busy_q;

  logic                  wr_en;
  logic                  tx_take;
  logic                  out_free;
  logic [DW-1:0]         mem [DEPTH];
  logic [DW-1:0]         rdata_q;
  logic [SAMPLE_WIDTH-1:0] sample;
  logic [15:0]           sample16;

  assign tx_take  = tx_valid_q & i_tx_ready;
  assign out_free = ~tx_valid_q | i_tx_ready;

  always_comb begin
    sample = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_q == CH_W'(k)) sample = rdata_q[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    end
  end

  assign sample16 = 16'(sample);

  // Synchronous RAM: read data appears one cycle after rd_ptr_q settles.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr_q] <= i_sample_data;
    rdata_q <= mem[rd_ptr_q];
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    trig_ptr_d = trig_ptr_q;
    cnt_d      = cnt_q;
    smp_d      = smp_q;
    hdr_d      = hdr_q;
    ch_d       = ch_q;
    lo_d       = lo_q;
    fetch_d    = fetch_q;
    last_d     = last_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    done_d     = 1'b0;
    wr_en      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_arm) begin
          wr_ptr_d = '0;
          cnt_d    = '0;
          state_d  = (c_pretrig == '0) ? S_WAIT_TRIG : S_PREFILL;
        end
      end

      S_PREFILL: begin
        if (i_sample_valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + c_one;
          cnt_d    = cnt_q + c_one;
          if (cnt_q == c_pretrig - c_one) begin
            cnt_d   = '0;
            state_d = S_WAIT_TRIG;
          end
        end
      end

      S_WAIT_TRIG: begin
        if (i_sample_valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + c_one;
          if (i_trigger) begin
            trig_ptr_d = wr_ptr_q;
            cnt_d      = '0;
            state_d    = S_POST;
          end
        end
      end

      S_POST: begin
        if (cnt_q == c_postcnt) begin
          rd_ptr_d = trig_ptr_q - c_pretrig;
          smp_d    = '0;
          hdr_d    = 2'd0;
          ch_d     = '0;
          lo_d     = 1'b0;
          fetch_d  = 1'b1;
          last_d   = 1'b0;
          state_d  = S_READOUT;
        end else if (i_sample_valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + c_one;
          cnt_d    = cnt_q + c_one;
        end
      end

      S_READOUT: begin
        fetch_d = 1'b0;
        if (tx_take && last_q) begin
          tx_valid_d = 1'b0;
          done_d     = 1'b1;
          state_d    = S_DONE;
        end else if (out_free) begin
          if (hdr_q == 2'd0) begin
            tx_data_d  = c_sync;
            tx_valid_d = 1'b1;
            hdr_d      = 2'd1;
          end else if (hdr_q == 2'd1) begin
            tx_data_d  = c_nch;
            tx_valid_d = 1'b1;
            hdr_d      = 2'd2;
          end else if (!fetch_q && !last_q) begin
            tx_data_d  = lo_q ? sample16[7:0] : sample16[15:8];
            tx_valid_d = 1'b1;
            if (!lo_q) begin
              lo_d = 1'b1;
            end else begin
              lo_d = 1'b0;
              if (ch_q == c_last_ch) begin
                ch_d = '0;
                // Advancing the address costs one bubble while the RAM catches up.
                if (smp_q == c_last) begin
                  last_d = 1'b1;
                end else begin
                  smp_d    = smp_q + c_one;
                  rd_ptr_d = rd_ptr_q + c_one;
                  fetch_d  = 1'b1;
                end
              end else begin
                ch_d = ch_q + CH_W'(1);
              end
            end
          end else begin
            tx_valid_d = 1'b0;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_RESET) begin
    if (i_RESET) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      trig_ptr_q <= '0;
      cnt_q      <= '0;
      smp_q      <= '0;
      hdr_q      <= 2'd0;
      ch_q       <= '0;
      lo_q       <= 1'b0;
      fetch_q    <= 1'b0;
      last_q     <= 1'b0;
      tx_data_q  <= 8'd0;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      armed_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      trig_ptr_q <= trig_ptr_d;
      cnt_q      <= cnt_d;
      smp_q      <= smp_d;
      hdr_q      <= hdr_d;
      ch_q       <= ch_d;
      lo_q       <= lo_d;
      fetch_q    <= fetch_d;
      last_q     <= last_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      done_q     <= done_d;
      armed_q    <= (state_d == S_PREFILL) || (state_d == S_WAIT_TRIG) || (state_d == S_POST);
      busy_q     <= (state_d != S_IDLE);
    end
  end

  assign o_tx_data       = tx_data_q;
  assign o_tx_valid      = tx_valid_q;
  assign o_armed         = armed_q;
  assign o_busy          = busy_q;
  assign o_TRANSFER_DONE = done_q;

endmodule
`default_nettype wire

// File: tb/tb_capture_datapath_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_capture_datapath_mc
// Purpose  : Randomised capture/readout bench for capture_datapath_mc.
// Revision : 1.0
// ============================================================================
module tb_capture_datapath_mc;

  localparam int SW        = 12;
  localparam int NCH       = 2;
  localparam int DEPTH     = 16;
  localparam int AW        = 4;
  localparam int PRE       = 4;
  localparam int DW        = NCH * SW;
  localparam int FRAME_LEN = 2 + 2 * NCH * DEPTH;

  logic          clk = 1'b0;
  logic          rst;
  logic          arm;
  logic          sv;
  logic          trig;
  logic          rdy = 1'b1;
  logic [DW-1:0] sd;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          armed;
  logic          busy;
  logic          done;

  capture_datapath_mc #(
    .SAMPLE_WIDTH(SW),
    .NUM_CH      (NCH),
    .DEPTH       (DEPTH),
    .ADDR_WIDTH  (AW),
    .PRETRIG     (PRE)
  ) dut (
    .i_clk          (clk),
    .i_RESET        (rst),
    .i_arm          (arm),
    .i_sample_valid (sv),
    .i_sample_data  (sd),
    .i_trigger      (trig),
    .i_tx_ready     (rdy),
    .o_tx_data      (tx_data),
    .o_tx_valid     (tx_valid),
    .o_armed        (armed),
    .o_busy         (busy),
    .o_TRANSFER_DONE(done)
  );

  always #5 clk = ~clk;

  int          n_checks   = 0;
  int          n_errors   = 0;
  int          done_cnt   = 0;
  int          ready_pct  = 100;
  int          wait_cyc;
  int          trig_sel;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_data  = 8'd0;
  logic [7:0]  rx_q[$];
  logic [DW-1:0] hist [0:255];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rdy = ($urandom_range(99) < ready_pct);
    end
  end

  // Byte collector and handshake-stability observer
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_val("hold_valid", tx_valid, 1);
        check_val("hold_data", tx_data, prev_data);
      end
      if (tx_valid && rdy) rx_q.push_back(tx_data);
      if (done) done_cnt++;
      prev_stall = tx_valid && !rdy;
      prev_data  = tx_data;
    end
  end

  function automatic logic [DW-1:0] pattern(input int n, input bit rnd);
    if (rnd) return DW'($urandom);
    return {SW'(32'h800 + n), SW'(n)};
  endfunction

  // Frame byte idx for a capture whose trigger was the trig_n-th written sample.
  function automatic logic [7:0] exp_byte(input int trig_n, input int idx);
    logic [DW-1:0] w;
    logic [15:0]   v;
    int            j, s, k;
    if (idx == 0) return 8'hA5;
    if (idx == 1) return 8'(NCH);
    j = idx - 2;
    s = j / (2 * NCH);
    k = (j / 2) % NCH;
    w = hist[trig_n - PRE + s] >> (k * SW);
    v = 16'(w[SW-1:0]);
    return (j % 2 == 0) ? v[15:8] : v[7:0];
  endfunction

  task automatic do_capture(input int trig_n, input bit early, input int vprob,
                            input bit rnd, input int stop_n);
    int n = 0;
    int total;
    total = trig_n + DEPTH - PRE;
    if (stop_n >= 0 && stop_n < total) total = stop_n;
    rx_q.delete();
    done_cnt = 0;
    arm = 1'b1;
    @(posedge clk);
    #1;
    arm = 1'b0;
    check_val("armed_after_arm", armed, 1);
    check_val("busy_after_arm", busy, 1);
    while (n < total) begin
      if ($urandom_range(99) < vprob) begin
        sv      = 1'b1;
        sd      = pattern(n, rnd);
        hist[n] = sd;
        trig    = (n == trig_n) || (early && n < PRE);
        n++;
      end else begin
        sv   = 1'b0;
        sd   = pattern(0, 1'b1);
        trig = 1'($urandom_range(1));
      end
      @(posedge clk);
      #1;
    end
    sv   = 1'b0;
    trig = 1'b0;
  endtask

  task automatic wait_frame(input bit junk);
    int cyc = 0;
    while (done_cnt == 0 && cyc < 3000) begin
      if (junk) begin
        sv   = 1'($urandom_range(1));
        sd   = pattern(0, 1'b1);
        trig = 1'($urandom_range(1));
        arm  = (cyc == 30);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    sv   = 1'b0;
    trig = 1'b0;
    arm  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("done_pulses", done_cnt, 1);
    check_val("idle_busy", busy, 0);
    check_val("idle_armed", armed, 0);
  endtask

  task automatic check_frame(input int trig_n, input string tag);
    check_val({tag, "_len"}, rx_q.size(), FRAME_LEN);
    for (int i = 0; i < FRAME_LEN && i < rx_q.size(); i++) begin
      check_val($sformatf("%s_b%0d", tag, i), rx_q[i], exp_byte(trig_n, i));
    end
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_valid"}, tx_valid, 0);
    check_val({tag, "_data"}, tx_data, 0);
    check_val({tag, "_armed"}, armed, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
  endtask

  initial begin
    rst  = 1'b1;
    arm  = 1'b0;
    sv   = 1'b0;
    trig = 1'b0;
    sd   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic: counting pattern, trigger on sample 10
    ready_pct = 100;
    do_capture(10, 1'b0, 100, 1'b0, -1);
    wait_frame(1'b0);
    check_frame(10, "basic");
    if (rx_q.size() >= FRAME_LEN) begin
      check_val("basic_first", {rx_q[2], rx_q[3], rx_q[4], rx_q[5]}, 32'h00060806);
      check_val("basic_last", {rx_q[62], rx_q[63], rx_q[64], rx_q[65]}, 32'h00150815);
    end else begin
      check_val("basic_size", rx_q.size(), FRAME_LEN);
    end

    // Triggers during prefill are ignored; first valid one lands at sample 4
    do_capture(4, 1'b1, 100, 1'b0, -1);
    wait_frame(1'b0);
    check_frame(4, "early");

    // Buffer wraps several times before the trigger
    do_capture(40, 1'b0, 100, 1'b0, -1);
    wait_frame(1'b0);
    check_frame(40, "wrap");

    // Backpressure with the basic pattern
    ready_pct = 30;
    do_capture(10, 1'b0, 100, 1'b0, -1);
    wait_frame(1'b0);
    check_frame(10, "bp");

    // Arm, samples and triggers during readout must not disturb the frame
    ready_pct = 60;
    do_capture(25, 1'b0, 70, 1'b1, -1);
    wait_frame(1'b1);
    check_frame(25, "ign");

    // Reset in the post-trigger phase, then a fresh capture
    ready_pct = 100;
    do_capture(10, 1'b0, 100, 1'b1, 13);
    rst = 1'b1;
    #1;
    check_zero("rst_post");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_capture(12, 1'b0, 100, 1'b1, -1);
    wait_frame(1'b0);
    check_frame(12, "after_rst_post");

    // Reset in the middle of readout, then a fresh capture
    ready_pct = 50;
    do_capture(20, 1'b0, 100, 1'b1, -1);
    wait_cyc = 0;
    while (rx_q.size() < 20 && wait_cyc < 2000) begin
      @(posedge clk);
      #1;
      wait_cyc++;
    end
    check_val("ro_progress", rx_q.size() >= 20, 1);
    rst = 1'b1;
    #1;
    check_zero("rst_ro");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_val("no_done_after_rst", done_cnt, 0);
    check_val("idle_after_rst", busy, 0);
    do_capture(30, 1'b0, 80, 1'b1, -1);
    wait_frame(1'b0);
    check_frame(30, "after_rst_ro");

    // Random captures
    for (int r = 0; r < 4; r++) begin
      ready_pct = $urandom_range(20, 100);
      trig_sel  = $urandom_range(PRE, 60);
      do_capture(trig_sel, 1'($urandom_range(1)), $urandom_range(40, 100), 1'b1, -1);
      wait_frame(1'($urandom_range(1)));
      check_frame(trig_sel, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/capture_datapath_mc.md
Name: capture_datapath_mc

Overview:
- Parametrised multi-channel capture datapath and next generation of the single-channel capture/transfer path.
- Writes NUM_CH parallel sample streams into a circular buffer and holds a programmable pre-trigger window.
- Freezes the buffer after a trigger plus a post-trigger count.
- Streams the frame, oldest sample first, as bytes over a valid/ready interface to the PC serial transmitter.

Parameters:
- SAMPLE_WIDTH, 12, bits per channel sample (1..16).
- NUM_CH, 2, number of channels (1..8).
- DEPTH, 1024, samples per channel held in the buffer (power of 2).
- ADDR_WIDTH, 10, log2(DEPTH).
- PRETRIG, 256, samples kept before the trigger sample (0..DEPTH-1).

Ports:
- i_clk  in  1  system clock.
- i_RESET  in  1  asynchronous, active-high reset.
- i_arm  in  1  single-cycle pulse that starts a capture; ignored unless in IDLE.
- i_sample_valid  in  1  one sample set is present on i_sample_data.
- i_sample_data  in  NUM_CH*SAMPLE_WIDTH  channel k occupies bits [k*SAMPLE_WIDTH +: SAMPLE_WIDTH].
- i_trigger  in  1  trigger qualifier, sampled only together with i_sample_valid.
- i_tx_ready  in  1  transmitter accepts o_tx_data this cycle.
- o_tx_data  out  8  frame byte.
- o_tx_valid  out  1  o_tx_data is valid.
- o_armed  out  1  high in PREFILL, WAIT_TRIG and POST.
- o_busy  out  1  high in every state except IDLE.
- o_TRANSFER_DONE  out  1  one-cycle pulse after the last frame byte is accepted.

Behaviour:
- Clock and reset: single clock domain; i_RESET is asynchronous and active-high.
- Reset: state goes to IDLE; all counters and pointers go to 0; all outputs go to 0. This applies mid-capture and mid-readout; a partial frame is abandoned and o_TRANSFER_DONE is not pulsed.
- Buffer write: one write per i_sample_valid cycle in PREFILL, WAIT_TRIG and POST.
  - All channels are written at the same address wr_ptr.
  - wr_ptr increments mod DEPTH and wraps with no error.
- IDLE -> PREFILL on i_arm; wr_ptr = 0 and the sample count is cleared.
- PREFILL: counts written samples. When PRETRIG samples are written, go to WAIT_TRIG; with PRETRIG=0, go there immediately. i_trigger is ignored in PREFILL.
- WAIT_TRIG:
  - On i_sample_valid & i_trigger, that sample is written, trig_ptr = its address, and the state goes to POST.
  - Triggers with i_sample_valid low are ignored.
  - WAIT_TRIG may last indefinitely and the buffer overwrites itself.
- POST: writes DEPTH-PRETRIG-1 further samples, then goes to READOUT; if that count is 0, go to READOUT on the next cycle. Further triggers are ignored.
- READOUT start address rd_ptr = (trig_ptr - PRETRIG) mod DEPTH. The trigger sample is therefore sample index PRETRIG of the frame.
- Frame byte order:
  - Byte 0xA5 (sync), then a byte equal to NUM_CH.
  - Then, for sample i = 0..DEPTH-1 and for channel k = 0..NUM_CH-1: the sample zero-extended to 16 bits, high byte first, then low byte.
  - Total length = 2 + 2*NUM_CH*DEPTH bytes.
- Handshake:
  - A byte transfers when o_tx_valid & i_tx_ready.
  - While o_tx_valid is high and i_tx_ready is low, o_tx_data is held stable.
  - o_tx_valid may drop between bytes during RAM read latency, which is 1 cycle for the synchronous RAM.
  - i_tx_ready asserted while o_tx_valid is low has no effect.
- Samples arriving in READOUT or DONE are discarded and the buffer is not modified.
- READOUT -> DONE when the last byte transfers. DONE pulses o_TRANSFER_DONE for 1 cycle, then goes to IDLE.
- i_arm in the same cycle as the DONE -> IDLE transition is ignored.

Test Plan (DEPTH=16, ADDR_WIDTH=4, PRETRIG=4, NUM_CH=2, SAMPLE_WIDTH=12, i_tx_ready=1 unless stated):
- Basic: arm; feed ch0=n, ch1=0x800+n for n=0,1,2,…; trigger on n=10 -> frame is A5 02, first sample n=6 (00 06 08 06), 16 samples ending at n=21, 66 bytes, one o_TRANSFER_DONE pulse.
- Early trigger: assert i_trigger on n=0..3 (PREFILL) and first on n=4 -> trig_ptr=4; frame samples are n=0..15.
- Wrap: trigger at n=40 -> rd_ptr=(40-4) mod 16=4; frame samples are n=36..51 in order.
- Backpressure: toggle i_tx_ready randomly at 30% duty -> byte sequence is identical to the Basic case; o_tx_data is never changed while valid and not ready.
- Ignored inputs: i_arm during READOUT and a trigger with i_sample_valid=0 -> no effect; i_sample_valid during READOUT -> buffer contents unchanged.
- Reset: assert i_RESET mid-POST and again mid-READOUT -> all outputs 0 and state IDLE; a new arm yields a correct complete frame.
